// File: rtl/mux2_8_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready requesters.
// Bursts are capped so a continuously valid requester cannot starve the other port.
module mux2_8_rr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic             v0,
   output logic             r0,
   input  logic [WIDTH-1:0] d1,
   input  logic             v1,
   output logic             r1,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             sel,
   output logic             busy
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_ptr;
   logic               r_sel;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_y;
   logic               r_y_valid;

   state_t             w_state_nxt;
   state_t             w_oth_state;
   logic               w_ptr_nxt;
   logic               w_sel_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [CNT_W-1:0]   w_count_inc;
   logic [WIDTH-1:0]   w_y_nxt;
   logic               w_y_valid_nxt;
   logic               w_out_free;
   logic               w_r0;
   logic               w_r1;
   logic               w_xfer;
   logic               w_burst_end;
   logic               w_v_cur;
   logic               w_v_oth;
   logic               w_oth_ptr;

   // Output stage can accept a beat when empty or draining this cycle.
   assign w_out_free  = !r_y_valid || y_ready;
   assign w_r0        = (r_state == ST_GRANT0) && w_out_free;
   assign w_r1        = (r_state == ST_GRANT1) && w_out_free;
   assign w_xfer      = (v0 && w_r0) || (v1 && w_r1);
   assign w_count_inc = r_count + CNT_W'(1);
   assign w_burst_end = (w_count_inc == BURST_LAST);

   assign w_v_cur     = (r_state == ST_GRANT1) ? v1 : v0;
   assign w_v_oth     = (r_state == ST_GRANT1) ? v0 : v1;
   assign w_oth_state = (r_state == ST_GRANT1) ? ST_GRANT0 : ST_GRANT1;
   assign w_oth_ptr   = (r_state == ST_GRANT0);

   // Next-state, pointer, burst count and output-stage logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_count_nxt   = r_count;
      w_sel_nxt     = r_sel;
      w_y_nxt       = r_y;
      w_y_valid_nxt = r_y_valid;

      case (r_state)
         ST_IDLE: begin
            if (v0 && (!v1 || r_ptr)) begin
               w_state_nxt = ST_GRANT0;
               w_ptr_nxt   = 1'b0;
               w_count_nxt = '0;
            end else if (v1) begin
               w_state_nxt = ST_GRANT1;
               w_ptr_nxt   = 1'b1;
               w_count_nxt = '0;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (w_xfer && w_burst_end) begin
               w_count_nxt = '0;
               if (w_v_oth) begin
                  w_state_nxt = w_oth_state;
                  w_ptr_nxt   = w_oth_ptr;
               end
            end else if (!w_v_cur) begin
               if (w_v_oth) begin
                  w_state_nxt = w_oth_state;
                  w_ptr_nxt   = w_oth_ptr;
                  w_count_nxt = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_xfer) begin
               w_count_nxt = w_count_inc;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
         end
      endcase

      // Select follows the granted port; IDLE keeps the last value.
      case (w_state_nxt)
         ST_GRANT0: w_sel_nxt = 1'b0;
         ST_GRANT1: w_sel_nxt = 1'b1;
         default:   w_sel_nxt = r_sel;
      endcase

      if (w_xfer) begin
         w_y_nxt       = r_sel ? d1 : d0;
         w_y_valid_nxt = 1'b1;
      end else if (r_y_valid && y_ready) begin
         w_y_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 1'b1;
         r_sel     <= 1'b0;
         r_count   <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sel     <= w_sel_nxt;
         r_count   <= w_count_nxt;
         r_y       <= w_y_nxt;
         r_y_valid <= w_y_valid_nxt;
      end
   end

   assign r0      = w_r0;
   assign r1      = w_r1;
   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign sel     = r_sel;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux2_8_rr_arbiter.sv
// Directed self-checking bench for mux2_8_rr_arbiter: reset, streaming,
// fairness, back-pressure, early release and mid-burst reset.
module tb_mux2_8_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] d0;
   logic       v0;
   logic       r0;
   logic [7:0] d1;
   logic       v1;
   logic       r1;
   logic [7:0] y;
   logic       y_valid;
   logic       y_ready;
   logic       sel;
   logic       busy;

   int checks;
   int errors;

   mux2_8_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d0      (d0),
      .v0      (v0),
      .r0      (r0),
      .d1      (d1),
      .v1      (v1),
      .r1      (r1),
      .y       (y),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .sel     (sel),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'hEE; d1 = 8'hDD; y_ready = 1'b1;
      step(); step();
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h exp 00", y); end
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b exp 0", y_valid); end
      checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got r0=%b r1=%b exp 0 0", r0, r1); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b exp 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      rst_n = 1'b1;
      step();
      checks++; if (busy !== 1'b1 || sel !== 1'b0) begin errors++; $display("FAIL reset_grant0: got busy=%b sel=%b exp 1 0", busy, sel); end
      checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL reset_r0: got r0=%b r1=%b exp 1 0", r0, r1); end
      v0 = 1'b0; v1 = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b yv=%b exp 0 0", busy, y_valid); end
   endtask

   task automatic test_single();
      v1 = 1'b1; d1 = 8'hA5; y_ready = 1'b1;
      step();
      checks++; if (sel !== 1'b1 || busy !== 1'b1 || y_valid !== 1'b0) begin errors++; $display("FAIL single_grant: got sel=%b busy=%b yv=%b exp 1 1 0", sel, busy, y_valid); end
      checks++; if (r1 !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL single_ready: got r0=%b r1=%b exp 0 1", r0, r1); end
      step();
      checks++; if (y !== 8'hA5 || y_valid !== 1'b1) begin errors++; $display("FAIL single_beat0: got %h/%b exp a5/1", y, y_valid); end
      d1 = 8'h5A;
      step();
      checks++; if (y !== 8'h5A || y_valid !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL single_beat1: got %h/%b sel=%b exp 5a/1 sel=1", y, y_valid, sel); end
      d1 = 8'hFF;
      step();
      checks++; if (y !== 8'hFF || y_valid !== 1'b1) begin errors++; $display("FAIL single_beat2: got %h/%b exp ff/1", y, y_valid); end
      v1 = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || y_valid !== 1'b0 || y !== 8'hFF) begin errors++; $display("FAIL single_idle: got busy=%b yv=%b y=%h exp 0 0 ff", busy, y_valid, y); end
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL single_sel_hold: got %b exp 1", sel); end
   endtask

   task automatic test_fairness();
      int i0;
      int i1;
      int port;
      logic [7:0] exp_y;
      logic       exp_sel;
      i0 = 0; i1 = 0;
      v0 = 1'b1; v1 = 1'b1; d0 = 8'h10; d1 = 8'h20; y_ready = 1'b1;
      step();
      checks++; if (sel !== 1'b0 || busy !== 1'b1 || y_valid !== 1'b0) begin errors++; $display("FAIL fair_grant: got sel=%b busy=%b yv=%b exp 0 1 0", sel, busy, y_valid); end
      for (int b = 0; b < 12; b++) begin
         port = (b / 4) % 2;
         if (port == 0) begin
            d0 = 8'h10 + 8'(i0); exp_y = d0; i0++;
         end else begin
            d1 = 8'h20 + 8'(i1); exp_y = d1; i1++;
         end
         exp_sel = 1'(((b + 1) / 4) % 2);
         step();
         checks++; if (y !== exp_y || y_valid !== 1'b1) begin errors++; $display("FAIL fair_beat%0d: got %h/%b exp %h/1", b, y, y_valid, exp_y); end
         checks++; if (sel !== exp_sel) begin errors++; $display("FAIL fair_sel%0d: got %b exp %b", b, sel, exp_sel); end
      end
      v0 = 1'b0; v1 = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL fair_idle: got busy=%b yv=%b exp 0 0", busy, y_valid); end
   endtask

   task automatic test_back_pressure();
      v0 = 1'b1; d0 = 8'h11; y_ready = 1'b1;
      step();
      checks++; if (sel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_grant: got sel=%b busy=%b exp 0 1", sel, busy); end
      v1 = 1'b1; d1 = 8'h99;
      step();
      checks++; if (y !== 8'h11 || y_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got %h/%b exp 11/1", y, y_valid); end
      y_ready = 1'b0; d0 = 8'h22;
      #1;
      checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL bp_r0_low: got %b exp 0", r0); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (y !== 8'h11 || y_valid !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got y=%h yv=%b r0=%b exp 11 1 0", k, y, y_valid, r0); end
      end
      y_ready = 1'b1;
      #1;
      checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL bp_r0_high: got %b exp 1", r0); end
      step();
      checks++; if (y !== 8'h22 || y_valid !== 1'b1) begin errors++; $display("FAIL bp_resume: got %h/%b exp 22/1", y, y_valid); end
      d0 = 8'h33;
      step();
      checks++; if (y !== 8'h33 || sel !== 1'b0) begin errors++; $display("FAIL bp_beat3: got %h sel=%b exp 33 sel=0", y, sel); end
      d0 = 8'h44;
      step();
      // Fourth beat of the burst ends the grant; a stall that counted would switch earlier.
      checks++; if (y !== 8'h44 || sel !== 1'b1) begin errors++; $display("FAIL bp_burst_end: got %h sel=%b exp 44 sel=1", y, sel); end
      v0 = 1'b0;
      step();
      checks++; if (y !== 8'h99 || y_valid !== 1'b1) begin errors++; $display("FAIL bp_other: got %h/%b exp 99/1", y, y_valid); end
      v1 = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b yv=%b exp 0 0", busy, y_valid); end
   endtask

   task automatic test_early_release();
      v0 = 1'b1; d0 = 8'hA0; y_ready = 1'b1;
      step();
      checks++; if (sel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL er_grant: got sel=%b busy=%b exp 0 1", sel, busy); end
      step();
      checks++; if (y !== 8'hA0) begin errors++; $display("FAIL er_beat0: got %h exp a0", y); end
      d0 = 8'hA1; v1 = 1'b1; d1 = 8'h3C;
      step();
      checks++; if (y !== 8'hA1 || sel !== 1'b0) begin errors++; $display("FAIL er_beat1: got %h sel=%b exp a1 sel=0", y, sel); end
      v0 = 1'b0;
      step();
      checks++; if (sel !== 1'b1 || r1 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL er_switch: got sel=%b r1=%b busy=%b exp 1 1 1", sel, r1, busy); end
      checks++; if (y_valid !== 1'b0 || y !== 8'hA1) begin errors++; $display("FAIL er_hold: got %h/%b exp a1/0", y, y_valid); end
      step();
      checks++; if (y !== 8'h3C || y_valid !== 1'b1) begin errors++; $display("FAIL er_d1: got %h/%b exp 3c/1", y, y_valid); end
      v1 = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL er_idle: got busy=%b exp 0", busy); end
   endtask

   task automatic test_mid_reset();
      v1 = 1'b1; d1 = 8'h77; y_ready = 1'b1;
      step();
      step();
      checks++; if (y !== 8'h77 || y_valid !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL mr_pre: got %h/%b sel=%b exp 77/1 sel=1", y, y_valid, sel); end
      rst_n = 1'b0; v0 = 1'b1; d0 = 8'h5E;
      step();
      checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL mr_out: got %h/%b exp 00/0", y, y_valid); end
      checks++; if (sel !== 1'b0 || busy !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL mr_ctl: got sel=%b busy=%b r0=%b r1=%b exp 0 0 0 0", sel, busy, r0, r1); end
      rst_n = 1'b1;
      step();
      checks++; if (sel !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL mr_tie: got sel=%b r0=%b r1=%b exp 0 1 0", sel, r0, r1); end
      step();
      checks++; if (y !== 8'h5E || y_valid !== 1'b1) begin errors++; $display("FAIL mr_beat: got %h/%b exp 5e/1", y, y_valid); end
      v0 = 1'b0; v1 = 1'b0;
      step();
   endtask

   initial begin
      clk = 1'b0;
      checks = 0; errors = 0;
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; y_ready = 1'b1;
      test_reset();
      test_single();
      test_fairness();
      test_back_pressure();
      test_early_release();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
